seq_nibble_adder: RTL and testbench

SEQ_NIBBLE_ADDER -- requirements
Module: seq_nibble_adder

---
 rtl/seq_add_pkg.sv | 17 +
 rtl/add4_slice.sv | 29 ++
 rtl/seq_nibble_adder.sv | 133 +++++++++++++
 tb/tb_seq_nibble_adder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_add_pkg.sv
// Shared constants, FSM state type and parameter check for the sequential nibble adder.
package seq_add_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operand width must be a whole number of nibbles, at least one.
  function automatic bit width_ok(input int unsigned w);
    return (w >= NIB_W) && ((w % NIB_W) == 0);
  endfunction

endpackage

// File: rtl/add4_slice.sv
// 4-bit ripple-carry slice built from full-adder cells; also exposes carry into bit 3.
module add4_slice
  import seq_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             c3
);

  logic [NIB_W:0] c;

  // Ripple chain of full adders.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < NIB_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[NIB_W];
  assign c3 = c[NIB_W-1];

endmodule

// File: rtl/seq_nibble_adder.sv
// Sequential adder: one nibble per cycle through a shared 4-bit slice.
// Optional SEQ_ADD_SUB_EN adds a 'sub' port selecting a-b.
module seq_nibble_adder
  import seq_add_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef SEQ_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned NIB_CNT = W / NIB_W;
  localparam int unsigned KW      = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB_CNT - 1);

  // Elaboration-time guard on the operand width.
  if (!width_ok(W)) begin : g_bad_width
    $error("seq_nibble_adder: W must be a multiple of 4 and at least 4");
  end

  state_t          state;
  state_t          state_next;
  logic [KW-1:0]   k;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            carry;
  logic            accept;
  logic            last;
  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] slice_s;
  logic            slice_co;
  logic            slice_c3;
  logic [W-1:0]    b_eff;
  logic            c_eff;

  assign last  = (k == K_LAST);
  assign nib_a = NIB_W'(op_a >> (NIB_W * k));
  assign nib_b = NIB_W'(op_b >> (NIB_W * k));

`ifdef SEQ_ADD_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif

  add4_slice u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  // Next-state decode.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Operand capture and per-nibble accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b_eff;
      carry <= c_eff;
      k     <= '0;
    end else if (state == RUN) begin
      for (int unsigned i = 0; i < NIB_CNT; i++) begin
        if (KW'(i) == k) sum[i*NIB_W +: NIB_W] <= slice_s;
      end
      carry <= slice_co;
      k     <= k + KW'(1);
      if (last) begin
        cout <= slice_co;
        ovf  <= slice_c3 ^ slice_co;
      end
    end
  end

endmodule

// File: tb/tb_seq_nibble_adder.sv
// Self-checking bench for seq_nibble_adder (W=16): vector table, scoreboard, corner sequences.
module tb_seq_nibble_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SEQ_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_nibble_adder #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: W-bit add with carry-in, optional subtract.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    res_t         r;
    logic [W-1:0] yy;
    logic         cc;
    logic [W:0]   full;
    logic [W-1:0] low;
    yy     = s ? ~y : y;
    cc     = s ? 1'b1 : c;
    full   = {1'b0, x} + {1'b0, yy} + (W+1)'(cc);
    low    = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + W'(cc);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = low[W-1] ^ full[W];
    return r;
  endfunction

  // Drive one operand set and push its expected result when it transfers.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input logic s, input res_t exp);
    int n = 0;
    @(negedge clk);
    a = x; b = y; cin = c;
`ifdef SEQ_ADD_SUB_EN
    sub = s;
`endif
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", W'(in_ready), W'(1));
    sb.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count rising edges until out_valid is seen.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) chk("out_valid_timeout", W'(out_valid), W'(1));
  endtask

  // Compare the presented result against the scoreboard head.
  task automatic recv(input string name);
    res_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, W'(1), W'(0));
      return;
    end
    e = sb.pop_front();
    chk({name, "_sum"},  sum,      e.sum);
    chk({name, "_cout"}, W'(cout), W'(e.cout));
    chk({name, "_ovf"},  W'(ovf),  W'(e.ovf));
  endtask

  task automatic xfer();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   cyc;
    int   nval;
    res_t r;
    logic [W-1:0] ra, rb;
    logic         rc;

    tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
    tbl.push_back('{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
`ifdef SEQ_ADD_SUB_EN
    tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    tbl.push_back('{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef SEQ_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_sum",       sum,           W'(0));
    chk("rst_cout",      W'(cout),      W'(0));
    chk("rst_ovf",       W'(ovf),       W'(0));
    rst_n = 1'b1;

    // Table of fixed vectors with known results.
    foreach (tbl[i]) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
           '{tbl[i].sum, tbl[i].cout, tbl[i].ovf});
      wait_out(cyc);
      chk($sformatf("tbl%0d_latency", i), W'(cyc), W'(4));
      chk($sformatf("tbl%0d_in_ready", i), W'(in_ready), W'(0));
      recv($sformatf("tbl%0d", i));
      xfer();
      chk($sformatf("tbl%0d_back_idle", i), W'(in_ready), W'(1));
    end

    // Random additions checked against the model.
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(1));
      send(ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
      wait_out(cyc);
      chk($sformatf("rnd%0d_latency", i), W'(cyc), W'(4));
      recv($sformatf("rnd%0d", i));
      xfer();
    end

    // Untouched nibbles keep old contents; in_valid during RUN is ignored.
    send(16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0});
    wait_out(cyc);
    recv("pre_hold");
    xfer();
    send(16'h0001, 16'h0001, 1'b0, 1'b0, '{16'h0002, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    chk("hold_partial_sum", sum, 16'h5552);
    chk("run_in_ready", W'(in_ready), W'(0));
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    wait_out(cyc);
    chk("hold_remaining_latency", W'(cyc), W'(3));
    in_valid = 1'b0;
    recv("run_ignore");
    xfer();

    // Throughput with out_ready held high: accept-to-accept spacing.
    out_ready = 1'b1;
    send(16'h0101, 16'h0202, 1'b0, 1'b0, '{16'h0303, 1'b0, 1'b0});
    wait_out(cyc);
    recv("thr0");
    nval = 0;
    begin
      time t0;
      t0 = $time;
      send(16'h1111, 16'h2222, 1'b1, 1'b0, '{16'h3334, 1'b0, 1'b0});
      // send returns 1 time unit after its accept edge; previous output was seen the same way.
      chk("thr_spacing_cycles", W'(int'(($time - t0) / 10)), W'(2));
    end
    wait_out(cyc);
    recv("thr1");
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Backpressure: result stable and new operands held off while out_ready=0.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0});
    wait_out(cyc);
    a = 16'h0003; b = 16'h0004; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_sum", i), sum, sb[0].sum);
      chk($sformatf("bp%0d_flags", i), W'({cout, ovf}), W'({sb[0].cout, sb[0].ovf}));
      chk($sformatf("bp%0d_in_ready", i), W'(in_ready), W'(0));
      chk($sformatf("bp%0d_out_valid", i), W'(out_valid), W'(1));
    end
    recv("bp_result");
    xfer();
    chk("bp_ready_after_xfer", W'(in_ready), W'(1));
    sb.push_back(model(16'h0003, 16'h0004, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_new_accepted", W'(in_ready), W'(0));
    wait_out(cyc);
    chk("bp_new_latency", W'(cyc), W'(4));
    recv("bp_new");
    xfer();

    // Reset during RUN aborts the operation.
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0, model(16'hAAAA, 16'h5555, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("abort_in_ready",  W'(in_ready),  W'(1));
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_sum",       sum,           W'(0));
    chk("abort_flags",     W'({cout, ovf}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_back());
    nval = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) nval++;
    end
    chk("abort_no_out_valid", W'(nval), W'(0));
    send(16'h0F0F, 16'h00F1, 1'b1, 1'b0, '{16'h1001, 1'b0, 1'b0});
    wait_out(cyc);
    chk("post_abort_latency", W'(cyc), W'(4));
    recv("post_abort");
    xfer();

    chk("sb_drained", W'(sb.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
